timer_reg_arbiter: RTL and testbench

- Two-port register-access controller sitting in front of the d_ip_timer register interface (addr/wdata/wr_en/mod_en/rdata).
- Arbitrates single-beat read/write commands from two requesters (port 0 = host, port 1 = sequencer/self-test) with round-robin fairness.
- Drives the timer bus one access at a time, captures read data after a fixed latency, and returns a completion pulse to the winning requester.

---
 rtl/timer_reg_arbiter_pkg.sv | 23 ++
 rtl/timer_reg_arbiter_if.sv | 38 +++
 rtl/timer_reg_arbiter_rr_arb2.sv | 20 ++
 rtl/timer_reg_arbiter.sv | 114 +++++++++++
 tb/tb_timer_reg_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_reg_arbiter_pkg.sv
// Shared types and default widths for the two-port timer register arbiter.
package timer_ctrl_pkg;

    // Default timer register interface widths.
    localparam int TMR_ADDR_W = 6;
    localparam int TMR_DATA_W = 8;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } tmr_arb_state_e;

    // Command captured from the winning port at accept time.
    typedef struct packed {
        logic                  wr;
        logic [TMR_ADDR_W-1:0] addr;
        logic [TMR_DATA_W-1:0] wdata;
    } tmr_cmd_t;

endpackage

// File: rtl/timer_reg_arbiter_if.sv
// Requester and timer-bus signals of the timer register arbiter.
//
// Request handshake: port i presents a command while req_valid[i] is high and
// must hold it, unchanged, until the cycle in which req_ready[i] is high; the
// command is taken in that cycle. Each accepted command is answered by exactly
// one single-cycle rsp_done[i] pulse; rsp_rdata is meaningful for reads only
// in that pulse cycle.
interface timer_reg_arbiter_if #(
    parameter int ADDR_W = timer_ctrl_pkg::TMR_ADDR_W,
    parameter int DATA_W = timer_ctrl_pkg::TMR_DATA_W
);
    logic [1:0]          req_valid;
    logic [1:0]          req_wr;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_done;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [ADDR_W-1:0]   t_addr;
    logic [DATA_W-1:0]   t_wdata;
    logic                t_wr_en;
    logic                t_mod_en;
    logic [DATA_W-1:0]   t_rdata;
    logic                busy;

    // Arbiter side.
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, t_rdata,
        output req_ready, rsp_done, rsp_rdata, t_addr, t_wdata, t_wr_en, t_mod_en, busy
    );

    // Requesters plus timer side.
    modport master (
        output req_valid, req_wr, req_addr, req_wdata, t_rdata,
        input  req_ready, rsp_done, rsp_rdata, t_addr, t_wdata, t_wr_en, t_mod_en, busy
    );

endinterface

// File: rtl/timer_reg_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time
// is granted; a lone request is always granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // One-hot grant selection.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/timer_reg_arbiter.sv
// Two-port register-access controller in front of the timer register bus.
// One single-beat command at a time: accept, issue, optional read wait, respond.
module timer_reg_arbiter
    import timer_ctrl_pkg::*;
#(
    parameter int ADDR_W = TMR_ADDR_W,
    parameter int DATA_W = TMR_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    timer_reg_arbiter_if.slave   bus,
    output tmr_arb_state_e       dbg_state
);

    // WAIT lasts RD_LAT cycles; the counter starts at RD_LAT-1 and the
    // capture happens when it reaches zero.
    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

    tmr_arb_state_e    state;
    tmr_arb_state_e    state_nxt;
    tmr_cmd_t          cmd;
    logic              owner;
    logic              last_grant;
    logic [1:0]        gnt;
    logic              gsel;
    logic              accept;
    logic [2:0]        wait_cnt;
    logic [DATA_W-1:0] rdata_q;

    rr_arb2 u_rr_arb2 (
        .req  (bus.req_valid),
        .last (last_grant),
        .gnt  (gnt)
    );

    assign gsel   = gnt[1];
    assign accept = (state == IDLE) && (gnt != 2'b00);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = cmd.wr ? RESP : WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    // Command latch and round-robin history, updated only on a grant.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cmd        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            cmd.wr     <= bus.req_wr[gsel];
            cmd.addr   <= bus.req_addr[int'(gsel)*ADDR_W +: ADDR_W];
            cmd.wdata  <= bus.req_wdata[int'(gsel)*DATA_W +: DATA_W];
            owner      <= gsel;
            last_grant <= gsel;
        end
    end

    // Timer bus drive: loaded on accept so the strobe lands exactly in ISSUE;
    // address and data hold their last values afterwards.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bus.t_mod_en <= 1'b0;
            bus.t_wr_en  <= 1'b0;
            bus.t_addr   <= '0;
            bus.t_wdata  <= '0;
        end else begin
            bus.t_mod_en <= accept;
            bus.t_wr_en  <= accept & bus.req_wr[gsel];
            if (accept) begin
                bus.t_addr  <= bus.req_addr[int'(gsel)*ADDR_W +: ADDR_W];
                bus.t_wdata <= bus.req_wdata[int'(gsel)*DATA_W +: DATA_W];
            end
        end
    end

    // Read latency counter and read-data capture; writes leave rdata_q alone.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wait_cnt <= 3'd0;
            rdata_q  <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= WAIT_INIT;
        end else if (state == WAIT) begin
            if (wait_cnt == 3'd0) rdata_q  <= bus.t_rdata;
            else                  wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Combinational requester-side outputs.
    always_comb begin
        bus.req_ready = (state == IDLE) ? gnt : 2'b00;
        bus.rsp_done  = 2'b00;
        if (state == RESP) bus.rsp_done = owner ? 2'b10 : 2'b01;
        bus.rsp_rdata = rdata_q;
        bus.busy      = (state != IDLE);
        dbg_state     = state;
    end

endmodule

// File: tb/tb_timer_reg_arbiter.sv
`timescale 1ns/1ps
module tb_timer_reg_arbiter;
    import timer_ctrl_pkg::*;

    localparam int AW   = TMR_ADDR_W;
    localparam int DW   = TMR_DATA_W;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    localparam int S_READY = 0, S_MOD = 1, S_WR = 2, S_ADDR = 3, S_WDATA = 4;
    localparam int S_BUSY  = 5, S_DONE = 6, S_RDATA = 7, S_STATE = 8;

    localparam int EXP_W = 27;  // {dut, done[1:0], rdata[7:0], cycle[15:0]}
    localparam int PRB_W = 37;  // {dut, id[3:0], cycle[15:0], value[15:0]}

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    int   cyc   = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int tmo_req  = 0;
    int tmo_seen = 0;
    bit end_req  = 1'b0;
    bit end_ack  = 1'b0;
    int exp_cnt  [2][2];
    int done_cnt [2][2];

    logic [EXP_W-1:0] exp_q[$];
    logic [PRB_W-1:0] probe_q[$];

    logic [1:0]       drv_valid [2];
    logic [1:0]       drv_wr    [2];
    logic [2*AW-1:0]  drv_addr  [2];
    logic [2*DW-1:0]  drv_wdata [2];

    logic [1:0]       obs_ready [2];
    logic [1:0]       obs_done  [2];
    logic [DW-1:0]    obs_rdata [2];
    logic [AW-1:0]    obs_taddr [2];
    logic [DW-1:0]    obs_twdata[2];
    logic             obs_wr    [2];
    logic             obs_mod   [2];
    logic             obs_busy  [2];
    tmr_arb_state_e   obs_state [2];

    int               cont_n    [2];
    logic [AW-1:0]    cont_a    [2][2];
    logic [DW-1:0]    cont_wd   [2][2];

    // Timer register contents returned by the model.
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        case (a)
            6'h00:   rom = 8'h11;
            6'h01:   rom = 8'h7E;
            6'h04:   rom = 8'h3C;
            default: rom = {2'b10, a};
        endcase
    endfunction

    // ---------------- two DUTs: RD_LAT=1 (dut0) and RD_LAT=3 (dut1) ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? LAT0 : LAT1;
        timer_reg_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [DW:0] pipe [LAT];

        timer_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst_b     (rst_b),
            .bus       (bus),
            .dbg_state (obs_state[g])
        );

        assign bus.req_valid = drv_valid[g];
        assign bus.req_wr    = drv_wr[g];
        assign bus.req_addr  = drv_addr[g];
        assign bus.req_wdata = drv_wdata[g];
        assign bus.t_rdata   = pipe[LAT-1][DW] ? pipe[LAT-1][DW-1:0] : DW'('hEE);

        assign obs_ready[g]  = bus.req_ready;
        assign obs_done[g]   = bus.rsp_done;
        assign obs_rdata[g]  = bus.rsp_rdata;
        assign obs_taddr[g]  = bus.t_addr;
        assign obs_twdata[g] = bus.t_wdata;
        assign obs_wr[g]     = bus.t_wr_en;
        assign obs_mod[g]    = bus.t_mod_en;
        assign obs_busy[g]   = bus.busy;

        // Timer model: read data valid LAT cycles after the strobe cycle.
        always @(posedge clk) begin
            pipe[0] <= {bus.t_mod_en & ~bus.t_wr_en, rom(bus.t_addr)};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // ---------------- scoreboard helpers ----------------
    function automatic int lat_of(input int d);
        lat_of = (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic void probe(input int d, input int id, input int c, input logic [15:0] v);
        probe_q.push_back({1'(d), 4'(id), 16'(c), v});
    endfunction

    function automatic void expect_done(input int d, input int p, input logic [DW-1:0] rd, input int c);
        exp_q.push_back({1'(d), (p == 0) ? 2'b01 : 2'b10, rd, 16'(c)});
        exp_cnt[d][p] = exp_cnt[d][p] + 1;
    endfunction

    function automatic logic [15:0] get_sig(input int d, input int id);
        case (id)
            S_READY: get_sig = 16'(obs_ready[d]);
            S_MOD:   get_sig = 16'(obs_mod[d]);
            S_WR:    get_sig = 16'(obs_wr[d]);
            S_ADDR:  get_sig = 16'(obs_taddr[d]);
            S_WDATA: get_sig = 16'(obs_twdata[d]);
            S_BUSY:  get_sig = 16'(obs_busy[d]);
            S_DONE:  get_sig = 16'(obs_done[d]);
            S_RDATA: get_sig = 16'(obs_rdata[d]);
            S_STATE: get_sig = 16'(obs_state[d]);
            default: get_sig = 16'hDEAD;
        endcase
    endfunction

    function automatic string sig_name(input int id);
        case (id)
            S_READY: sig_name = "req_ready";
            S_MOD:   sig_name = "t_mod_en";
            S_WR:    sig_name = "t_wr_en";
            S_ADDR:  sig_name = "t_addr";
            S_WDATA: sig_name = "t_wdata";
            S_BUSY:  sig_name = "busy";
            S_DONE:  sig_name = "rsp_done";
            S_RDATA: sig_name = "rsp_rdata";
            S_STATE: sig_name = "state";
            default: sig_name = "unknown";
        endcase
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [PRB_W-1:0] pe;
        logic [EXP_W-1:0] ee;
        logic [15:0]      act;
        int               pd;
        forever begin
            @(negedge clk);
            for (int i = probe_q.size() - 1; i >= 0; i--) begin
                pe = probe_q[i];
                if (pe[31:16] == 16'(cyc)) begin
                    pd  = int'(pe[36]);
                    act = get_sig(pd, int'(pe[35:32]));
                    n_checks = n_checks + 1;
                    if (act !== pe[15:0]) begin
                        n_fail = n_fail + 1;
                        $display("FAIL %s dut%0d cycle %0d: got %h, expected %h",
                                 sig_name(int'(pe[35:32])), pd, cyc, act, pe[15:0]);
                    end
                    probe_q.delete(i);
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (obs_done[d] != 2'b00) begin
                    n_checks = n_checks + 1;
                    if (obs_done[d][0]) done_cnt[d][0] = done_cnt[d][0] + 1;
                    if (obs_done[d][1]) done_cnt[d][1] = done_cnt[d][1] + 1;
                    if (exp_q.size() == 0) begin
                        n_fail = n_fail + 1;
                        $display("FAIL rsp dut%0d cycle %0d: unexpected done=%b rdata=%h, expected no response",
                                 d, cyc, obs_done[d], obs_rdata[d]);
                    end else begin
                        ee = exp_q.pop_front();
                        if (ee !== {1'(d), obs_done[d], obs_rdata[d], 16'(cyc)}) begin
                            n_fail = n_fail + 1;
                            $display("FAIL rsp dut%0d: got done=%b rdata=%h at cycle %0d, expected dut%0d done=%b rdata=%h at cycle %0d",
                                     d, obs_done[d], obs_rdata[d], cyc, ee[26], ee[25:24], ee[23:16], ee[15:0]);
                        end
                    end
                end
            end
            if (tmo_req != tmo_seen) begin
                n_checks = n_checks + 1;
                n_fail   = n_fail + 1;
                $display("FAIL timeout: %0d handshake wait(s) expired, expected 0", tmo_req - tmo_seen);
                tmo_seen = tmo_req;
            end
            if (end_req && !end_ack) begin
                n_checks = n_checks + 2;
                if (exp_q.size() != 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL pending_rsp: got %0d unanswered, expected 0", exp_q.size());
                end
                if (probe_q.size() != 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL pending_probe: got %0d unchecked, expected 0", probe_q.size());
                end
                for (int d = 0; d < 2; d++) begin
                    for (int p = 0; p < 2; p++) begin
                        n_checks = n_checks + 1;
                        if (done_cnt[d][p] != exp_cnt[d][p]) begin
                            n_fail = n_fail + 1;
                            $display("FAIL done_count dut%0d port%0d: got %0d, expected %0d",
                                     d, p, done_cnt[d][p], exp_cnt[d][p]);
                        end
                    end
                end
                end_ack = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input int d, input int p, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, output int c);
        c = cyc;
        drv_wr[d][p]              = wr;
        drv_addr[d][p*AW +: AW]   = a;
        drv_wdata[d][p*DW +: DW]  = wd;
        drv_valid[d][p]           = 1'b1;
        probe(d, S_READY, c, (p == 0) ? 16'h1 : 16'h2);
        probe(d, S_MOD,   c + 1, 16'h1);
        probe(d, S_WR,    c + 1, 16'(wr));
        probe(d, S_ADDR,  c + 1, 16'(a));
        probe(d, S_WDATA, c + 1, 16'(wd));
    endtask

    task automatic wait_ready_drop(input int d, input int p);
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (obs_ready[d][p]) seen = 1'b1;
        end
        if (!seen) tmo_req = tmo_req + 1;
        @(posedge clk);
        #1;
        drv_valid[d][p] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        bit idle = 1'b0;
        for (int t = 0; t < 30 && !idle; t++) begin
            @(negedge clk);
            if (!obs_busy[d]) idle = 1'b1;
        end
        if (!idle) tmo_req = tmo_req + 1;
        tick(1);
    endtask

    task automatic do_cmd(input int d, input int p, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd_exp);
        int c;
        start_cmd(d, p, wr, a, wd, c);
        expect_done(d, p, rd_exp, c + (wr ? 2 : 2 + lat_of(d)));
        wait_ready_drop(d, p);
        wait_idle(d);
    endtask

    // Both ports present write commands from cont_* until each list is used up.
    task automatic run_contention(input int d, input int total);
        int  idx [2];
        int  p;
        bit  seen;
        for (int q = 0; q < 2; q++) begin
            idx[q] = 0;
            if (cont_n[q] > 0) begin
                drv_wr[d][q]             = 1'b1;
                drv_addr[d][q*AW +: AW]  = cont_a[q][0];
                drv_wdata[d][q*DW +: DW] = cont_wd[q][0];
                drv_valid[d][q]          = 1'b1;
            end
        end
        for (int k = 0; k < total; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (obs_ready[d] != 2'b00) seen = 1'b1;
            end
            if (!seen) begin
                tmo_req = tmo_req + 1;
                break;
            end
            p = obs_ready[d][1] ? 1 : 0;
            tick(1);
            idx[p] = idx[p] + 1;
            if (idx[p] < cont_n[p]) begin
                drv_addr[d][p*AW +: AW]  = cont_a[p][idx[p]];
                drv_wdata[d][p*DW +: DW] = cont_wd[p][idx[p]];
            end else begin
                drv_valid[d][p] = 1'b0;
            end
        end
        drv_valid[d] = 2'b00;
        wait_idle(d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        for (int d = 0; d < 2; d++) begin
            drv_valid[d] = '0;
            drv_wr[d]    = '0;
            drv_addr[d]  = '0;
            drv_wdata[d] = '0;
            for (int p = 0; p < 2; p++) begin
                exp_cnt[d][p]  = 0;
                done_cnt[d][p] = 0;
            end
        end

        // Reset values while reset is held.
        tick(2);
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            probe(d, S_MOD, c, 16'h0);
            probe(d, S_WR, c, 16'h0);
            probe(d, S_ADDR, c, 16'h0);
            probe(d, S_WDATA, c, 16'h0);
            probe(d, S_DONE, c, 16'h0);
            probe(d, S_RDATA, c, 16'h0);
            probe(d, S_BUSY, c, 16'h0);
            probe(d, S_READY, c, 16'h0);
            probe(d, S_STATE, c, 16'(IDLE));
        end
        tick(1);
        rst_b = 1'b1;
        tick(1);

        // Single write, port 0: strobe at +1, done at +2, rsp_rdata still reset value.
        start_cmd(0, 0, 1'b1, 6'h02, 8'hA5, c);
        expect_done(0, 0, 8'h00, c + 2);
        probe(0, S_BUSY, c + 1, 16'h1);
        probe(0, S_MOD, c + 2, 16'h0);
        probe(0, S_ADDR, c + 3, 16'h02);
        wait_ready_drop(0, 0);
        wait_idle(0);

        // Single read, port 1, RD_LAT=1: done at +3 with 0x3C, no write enable.
        start_cmd(0, 1, 1'b0, 6'h04, 8'h00, c);
        expect_done(0, 1, 8'h3C, c + 3);
        probe(0, S_WR, c + 2, 16'h0);
        probe(0, S_WR, c + 3, 16'h0);
        probe(0, S_MOD, c + 2, 16'h0);
        wait_ready_drop(0, 1);
        wait_idle(0);

        // Contention: grants 0,1,0,1 three cycles apart; writes keep rsp_rdata at 0x3C.
        cont_n[0] = 2; cont_n[1] = 2;
        cont_a[0][0] = 6'h10; cont_wd[0][0] = 8'h01;
        cont_a[0][1] = 6'h11; cont_wd[0][1] = 8'h02;
        cont_a[1][0] = 6'h20; cont_wd[1][0] = 8'h03;
        cont_a[1][1] = 6'h21; cont_wd[1][1] = 8'h04;
        c = cyc;
        probe(0, S_READY, c,      16'h1);
        probe(0, S_READY, c + 3,  16'h2);
        probe(0, S_READY, c + 6,  16'h1);
        probe(0, S_READY, c + 9,  16'h2);
        probe(0, S_ADDR,  c + 1,  16'h10);
        probe(0, S_ADDR,  c + 4,  16'h20);
        probe(0, S_ADDR,  c + 7,  16'h11);
        probe(0, S_WDATA, c + 10, 16'h04);
        expect_done(0, 0, 8'h3C, c + 2);
        expect_done(0, 1, 8'h3C, c + 5);
        expect_done(0, 0, 8'h3C, c + 8);
        expect_done(0, 1, 8'h3C, c + 11);
        run_contention(0, 4);

        // RD_LAT=3 read of 0x01: done at +5 with 0x7E, busy through the wait.
        start_cmd(1, 0, 1'b0, 6'h01, 8'h00, c);
        expect_done(1, 0, 8'h7E, c + 5);
        for (int k = 1; k <= 4; k++) probe(1, S_BUSY, c + k, 16'h1);
        probe(1, S_STATE, c + 4, 16'(WAIT));
        probe(1, S_BUSY, c + 6, 16'h0);
        wait_ready_drop(1, 0);
        wait_idle(1);

        // Reset during WAIT of a port-0 read: no response, outputs cleared at once.
        start_cmd(1, 0, 1'b0, 6'h04, 8'h00, c);
        wait_ready_drop(1, 0);
        tick(1);
        probe(1, S_STATE, c + 2, 16'(IDLE));
        probe(1, S_MOD,   c + 2, 16'h0);
        probe(1, S_BUSY,  c + 2, 16'h0);
        probe(1, S_RDATA, c + 2, 16'h0);
        probe(0, S_RDATA, c + 2, 16'h0);
        for (int k = 2; k <= 7; k++) probe(1, S_DONE, c + k, 16'h0);
        rst_b = 1'b0;
        tick(2);
        rst_b = 1'b1;
        tick(4);

        // After reset port 0 wins the tie even though it won last before reset.
        cont_n[0] = 1; cont_n[1] = 1;
        cont_a[0][0] = 6'h05; cont_wd[0][0] = 8'h5A;
        cont_a[1][0] = 6'h06; cont_wd[1][0] = 8'h6B;
        c = cyc;
        probe(1, S_READY, c,     16'h1);
        probe(1, S_READY, c + 3, 16'h2);
        probe(1, S_ADDR,  c + 1, 16'h05);
        probe(1, S_WDATA, c + 4, 16'h6B);
        expect_done(1, 0, 8'h00, c + 2);
        expect_done(1, 1, 8'h00, c + 5);
        run_contention(1, 2);

        // Write after read: rsp_rdata keeps 0x11 through the write response.
        do_cmd(0, 0, 1'b0, 6'h00, 8'h00, 8'h11);
        start_cmd(0, 0, 1'b1, 6'h00, 8'hFF, c);
        expect_done(0, 0, 8'h11, c + 2);
        probe(0, S_RDATA, c + 4, 16'h11);
        wait_ready_drop(0, 0);
        wait_idle(0);

        tick(6);
        end_req = 1'b1;
        for (int t = 0; t < 10 && !end_ack; t++) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
